// File: rtl/right_shift_register_pkg.sv
// Shared constants for the right_shift_register block.
package right_shift_register_pkg;

    // Width used when a parent does not override WIDTH; must be 2 or more.
    localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/right_shift_register.sv
// Parallel-load, logical right-shift register; q[0] is the serial-out bit
// when serializing a word LSB-first.
module right_shift_register
    import right_shift_register_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             shift_en,
    output logic [WIDTH-1:0] q
);

    // Priority: reset, then load, then shift; load beats shift in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else if (shift_en) begin
            q <= {1'b0, q[WIDTH-1:1]};
        end
    end

endmodule

// File: tb/tb_right_shift_register.sv
// Self-checking bench for right_shift_register: directed scenarios plus a
// randomized run checked against an integer model of the register.
module tb_right_shift_register;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             load;
    logic [WIDTH-1:0] d;
    logic             shift_en;
    logic [WIDTH-1:0] q;

    int          compared   = 0;
    int          mismatched = 0;
    int unsigned model      = 0;
    bit          model_ok   = 1'b0;

    always #5 clk = ~clk;

    right_shift_register #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .d        (d),
        .shift_en (shift_en),
        .q        (q)
    );

    task automatic check(input string tag, input logic [WIDTH-1:0] exp);
        compared++;
        assert (q === exp) else begin
            mismatched++;
            $error("FAIL %s: q=%b expected %b", tag, q, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic exp);
        compared++;
        assert (q[0] === exp) else begin
            mismatched++;
            $error("FAIL %s: q[0]=%b expected %b", tag, q[0], exp);
        end
    endtask

    // Apply one command cycle; q must not move before the edge, and the model
    // follows the behavioural rules: clear, load the word, or halve it.
    task automatic drive(input logic r, input logic l, input logic [WIDTH-1:0] dv,
                         input logic s);
        @(negedge clk);
        rst = r; load = l; d = dv; shift_en = s;
        #1;
        if (model_ok) check("no_comb_path", model[WIDTH-1:0]);
        @(posedge clk);
        if (r) begin
            model    = 0;
            model_ok = 1'b1;
        end else if (l) begin
            model = int'(dv);
        end else if (s) begin
            model = model / 2;
        end
        #1;
    endtask

    initial begin
        logic [WIDTH-1:0] rd;
        logic             rr, rl, rs;

        rst = 1'b1; load = 1'b0; d = '0; shift_en = 1'b0;

        // Reset and idle hold
        drive(1, 0, 4'b0000, 0); check("reset", 4'b0000);
        drive(0, 0, 4'b0000, 0); check("reset_hold", 4'b0000);

        // Load then shift to empty, then stop shifting
        drive(0, 1, 4'b0110, 0); check("load_0110", 4'b0110);
        drive(0, 0, 4'b0000, 1); check("shift1", 4'b0011);
        drive(0, 0, 4'b0000, 1); check("shift2", 4'b0001);
        drive(0, 0, 4'b0000, 1); check("shift3", 4'b0000);
        drive(0, 0, 4'b0000, 1); check("shift_zero1", 4'b0000);
        drive(0, 0, 4'b0000, 1); check("shift_zero2", 4'b0000);
        drive(0, 0, 4'b0000, 0); check("idle_zero", 4'b0000);

        // Load beats shift
        drive(0, 1, 4'b1010, 0); check("load_1010", 4'b1010);
        drive(0, 1, 4'b0101, 1); check("load_over_shift", 4'b0101);

        // Hold
        drive(0, 1, 4'b1001, 0); check("load_1001", 4'b1001);
        drive(0, 0, 4'b0110, 0); check("hold1", 4'b1001);
        drive(0, 0, 4'b0110, 0); check("hold2", 4'b1001);

        // Reset beats load and shift mid-operation
        drive(0, 1, 4'b1111, 0); check("load_1111a", 4'b1111);
        drive(0, 0, 4'b0000, 1); check("mid_shift", 4'b0111);
        drive(1, 1, 4'b1100, 1); check("reset_priority", 4'b0000);
        drive(0, 0, 4'b1100, 1); check("post_reset_shift", 4'b0000);

        // Full-width drain with serial-out bit
        drive(0, 1, 4'b1111, 0); check("load_1111b", 4'b1111);
        drive(0, 0, 4'b0000, 1); check("drain1", 4'b0111); check_bit("sout1", 1'b1);
        drive(0, 0, 4'b0000, 1); check("drain2", 4'b0011); check_bit("sout2", 1'b1);
        drive(0, 0, 4'b0000, 1); check("drain3", 4'b0001); check_bit("sout3", 1'b1);
        drive(0, 0, 4'b0000, 1); check("drain4", 4'b0000); check_bit("sout4", 1'b0);

        // Level-sensitive load reloads every edge
        drive(0, 1, 4'b1011, 0); check("reload1", 4'b1011);
        drive(0, 1, 4'b0010, 0); check("reload2", 4'b0010);

        // Randomized commands against the model
        for (int i = 0; i < 300; i++) begin
            rr = ($urandom_range(0, 19) == 0);
            rl = ($urandom_range(0, 3) == 0);
            rs = ($urandom_range(0, 1) == 1);
            rd = WIDTH'($urandom);
            drive(rr, rl, rd, rs);
            check("random", model[WIDTH-1:0]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
